// File: rtl/data_sram_pkg.sv
// Shared types and constants for the data SRAM responder: FSM state encoding,
// latency counter width and byte-lane count.
package data_sram_pkg;

  localparam int LAT_CNT_W = 4;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_sram_slave_sram_bank.sv
// Word-organised storage with combinational read and a synchronous
// byte-masked write port.
module sram_bank
  import data_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_LANES-1:0]  wmask_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Contents are intentionally not reset; only enabled lanes are updated.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wmask_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_sram_slave.sv
// Fixed-latency data SRAM responder: accepts one load/store request, performs
// the access after LATENCY cycles and holds the response until it is taken.
module data_sram_slave
  import data_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_is_write
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "data_sram_slave: LATENCY must be within 1..15");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $fatal(1, "data_sram_slave: only DATA_WIDTH=32 is supported");
  end

  state_e                  state_q, state_d;
  logic [LAT_CNT_W-1:0]    cnt_q, cnt_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [NUM_LANES-1:0]    wmask_q, wmask_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    is_write_q, is_write_d;
  logic                    access_s;
  logic                    bank_we_s;
  logic [31:0]             bank_rdata_s;
  logic                    unused_addr_s;

  assign unused_addr_s = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  // The access happens on the last WAIT edge; reset on that edge aborts it.
  assign access_s  = (state_q == ST_WAIT) && (cnt_q == {LAT_CNT_W{1'b0}});
  assign bank_we_s = access_s && wen_q && !rst;

  sram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk     (clk),
    .we_i    (bank_we_s),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .wmask_i (wmask_q),
    .rdata_o (bank_rdata_s)
  );

  // Next-state and capture logic for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          idx_d   = req_addr[ADDR_WIDTH+1:2];
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (access_s) begin
          rdata_d    = wen_q ? 32'h0000_0000 : bank_rdata_s;
          is_write_d = wen_q;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {LAT_CNT_W{1'b0}};
      wen_q      <= 1'b0;
      idx_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= 32'h0000_0000;
      wmask_q    <= {NUM_LANES{1'b0}};
      rdata_q    <= 32'h0000_0000;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && !rst;
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_is_write = is_write_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave at LATENCY 1, 3 and 4 with a response
// scoreboard and cycle-accurate latency/backpressure checks.
module tb_data_sram_slave;

  typedef struct packed {
    logic        is_write;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst           [3];
  logic        req_valid     [3];
  logic        req_ready     [3];
  logic        req_wen       [3];
  logic [31:0] req_addr      [3];
  logic [31:0] req_wdata     [3];
  logic [3:0]  req_wmask     [3];
  logic        resp_valid    [3];
  logic        resp_ready    [3];
  logic [31:0] resp_rdata    [3];
  logic        resp_is_write [3];

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_slave #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk           (clk),
      .rst           (rst[g]),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_wen       (req_wen[g]),
      .req_addr      (req_addr[g]),
      .req_wdata     (req_wdata[g]),
      .req_wmask     (req_wmask[g]),
      .resp_valid    (resp_valid[g]),
      .resp_ready    (resp_ready[g]),
      .resp_rdata    (resp_rdata[g]),
      .resp_is_write (resp_is_write[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for acceptance, then scramble the request inputs.
  task automatic issue(input int k, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    int n;
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = mask;
    n = 0;
    while (!req_ready[k] && n < 40) begin
      tick();
      n++;
    end
    chk("req_accept_wait", 32'(req_ready[k]), 32'd1);
    tick();
    req_valid[k] = 1'b0;
    req_wen[k]   = ~wen;
    req_addr[k]  = 32'hFFFF_FFFC;
    req_wdata[k] = ~wdata;
    req_wmask[k] = ~mask;
  endtask

  task automatic txn(input int k, input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask, input logic [31:0] exp_rd);
    int   cyc;
    exp_t e;
    sb_q.push_back({wen, wen ? 32'h0000_0000 : exp_rd});
    resp_ready[k] = 1'b1;
    issue(k, wen, addr, wdata, mask);
    cyc = 1;
    while (!resp_valid[k] && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, ":latency"}, 32'(cyc), 32'(lat_of(k) + 1));
    e = sb_q.pop_front();
    chk({tag, ":rdata"}, resp_rdata[k], e.rdata);
    chk({tag, ":is_write"}, 32'(resp_is_write[k]), 32'(e.is_write));
    tick();
    chk({tag, ":resp_drop"}, 32'(resp_valid[k]), 32'd0);
    chk({tag, ":ready_again"}, 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      rst[k]        = 1'b1;
      req_valid[k]  = 1'b1;
      req_wen[k]    = 1'b1;
      req_addr[k]   = 32'h0000_0010;
      req_wdata[k]  = 32'h1357_9BDF;
      req_wmask[k]  = 4'b1111;
      resp_ready[k] = 1'b0;
    end

    // Reset held for three cycles with a request pending.
    for (int c = 0; c < 3; c++) tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst:req_ready", 32'(req_ready[k]), 32'd0);
      chk("rst:resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst:resp_rdata", resp_rdata[k], 32'h0000_0000);
      chk("rst:resp_is_write", 32'(resp_is_write[k]), 32'd0);
      rst[k]       = 1'b0;
      req_valid[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) chk("rst:ready_after_release", 32'(req_ready[k]), 32'd1);
    tick();

    // LATENCY=1: write then read, byte masks, no-op write, wrap-around.
    txn(0, "l1_wr10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    txn(0, "l1_rd10", 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF);
    txn(0, "l1_wr20", 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0);
    txn(0, "l1_wr22", 1'b1, 32'h0000_0022, 32'hAABB_CCDD, 4'b0100, 32'h0);
    txn(0, "l1_rd20", 1'b0, 32'h0000_0020, 32'h0, 4'b1111, 32'h11BB_3344);
    txn(0, "l1_wr20_m0", 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0);
    txn(0, "l1_rd20_m0", 1'b0, 32'h0000_0023, 32'h0, 4'b0000, 32'h11BB_3344);
    txn(0, "l1_wr24_m9", 1'b1, 32'h0000_0024, 32'h0102_0304, 4'b1111, 32'h0);
    txn(0, "l1_wr24_m9b", 1'b1, 32'h0000_0024, 32'hA0B0_C0D0, 4'b1001, 32'h0);
    txn(0, "l1_rd24", 1'b0, 32'h0000_0024, 32'h0, 4'b0000, 32'hA002_03D0);
    txn(0, "l1_wr400", 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 32'h0);
    txn(0, "l1_rd000", 1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'hCAFE_F00D);
    txn(0, "l1_rd410", 1'b0, 32'h0000_0411, 32'h0, 4'b0000, 32'hDEAD_BEEF);

    // LATENCY=3: response backpressure from cycle 4 through cycle 8.
    txn(1, "l3_wr40", 1'b1, 32'h0000_0040, 32'h0A0B_0C0D, 4'b1111, 32'h0);
    sb_q.push_back({1'b0, 32'h0A0B_0C0D});
    resp_ready[1] = 1'b0;
    issue(1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
    for (int c = 1; c <= 8; c++) begin
      chk("l3_bp:req_ready", 32'(req_ready[1]), 32'd0);
      chk("l3_bp:resp_valid", 32'(resp_valid[1]), (c >= 4) ? 32'd1 : 32'd0);
      if (c == 4) begin
        e = sb_q.pop_front();
        chk("l3_bp:rdata", resp_rdata[1], e.rdata);
        chk("l3_bp:is_write", 32'(resp_is_write[1]), 32'(e.is_write));
      end
      if (c > 4) chk("l3_bp:rdata_stable", resp_rdata[1], 32'h0A0B_0C0D);
      if (c == 8) resp_ready[1] = 1'b1;
      tick();
    end
    chk("l3_bp:ready_c9", 32'(req_ready[1]), 32'd1);
    chk("l3_bp:valid_c9", 32'(resp_valid[1]), 32'd0);
    txn(1, "l3_rd40", 1'b0, 32'h0000_0040, 32'h0, 4'b0000, 32'h0A0B_0C0D);

    // LATENCY=4: reset during the second WAIT cycle aborts a write.
    txn(2, "l4_wr30", 1'b1, 32'h0000_0030, 32'h1234_5678, 4'b1111, 32'h0);
    txn(2, "l4_rd30_old", 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 32'h1234_5678);
    resp_ready[2] = 1'b1;
    issue(2, 1'b1, 32'h0000_0030, 32'h5555_5555, 4'b1111);
    chk("l4_abort:wait1_ready", 32'(req_ready[2]), 32'd0);
    tick();
    rst[2] = 1'b1;
    tick();
    chk("l4_abort:rst_ready", 32'(req_ready[2]), 32'd0);
    chk("l4_abort:rst_valid", 32'(resp_valid[2]), 32'd0);
    rst[2] = 1'b0;
    #1;
    chk("l4_abort:ready_release", 32'(req_ready[2]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("l4_abort:no_resp", 32'(resp_valid[2]), 32'd0);
    end
    txn(2, "l4_rd30_after", 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 32'h1234_5678);
    txn(2, "l4_wr30_new", 1'b1, 32'h0000_0030, 32'h5555_5555, 4'b0011, 32'h0);
    txn(2, "l4_rd30_new", 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 32'h1234_5555);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
